// File: rtl/acog_seq.sv
// Per-cog pipeline sequencer: steps FETCH/DECODE/EXEC/WBACK, holds EXEC for hub
// and WAIT-class stalls, and owns run/halt with a restart pulse to write-back.
module acog_seq #(
   parameter bit BOOT_RUN = 1'b1,
   parameter int STALL_W  = 16
) (
   input  logic               clk_in,
   input  logic               resetn_in,
   input  logic               cog_start_in,
   input  logic               cog_stop_in,
   input  logic               execute_in,
   input  logic               is_hub_op_in,
   input  logic               is_wait_in,
   input  logic               hub_ack_in,
   input  logic               wait_done_in,
   output logic [1:0]         state_o,
   output logic               running_o,
   output logic               hub_req_o,
   output logic               stall_o,
   output logic               restart_o,
   output logic [STALL_W-1:0] stall_cnt_o
);

   localparam logic [1:0] ST_FETCH   = 2'd0;
   localparam logic [1:0] ST_DECODE  = 2'd1;
   localparam logic [1:0] ST_EXECUTE = 2'd2;
   localparam logic [1:0] ST_WBACK   = 2'd3;
   localparam logic [STALL_W-1:0] CNT_ONE = {{(STALL_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_HALT, S_FETCH, S_DECODE, S_EXEC, S_WBACK} seq_st_t;

   seq_st_t st;
   logic    stop_pend;
   logic    hub_op, wait_op, stall;

   // Hub wins over WAIT when both flags are set; a cancelled instruction never stalls.
   always_comb begin
      hub_op  = (st == S_EXEC) && execute_in && is_hub_op_in;
      wait_op = (st == S_EXEC) && execute_in && !is_hub_op_in && is_wait_in;
      stall   = (hub_op && !hub_ack_in) || (wait_op && !wait_done_in);
   end

   assign hub_req_o = hub_op;
   assign stall_o   = stall;

   always_ff @(posedge clk_in or negedge resetn_in) begin
      if (!resetn_in) begin
         st          <= BOOT_RUN ? S_FETCH : S_HALT;
         state_o     <= ST_FETCH;
         running_o   <= BOOT_RUN;
         restart_o   <= 1'b0;
         stall_cnt_o <= '0;
         stop_pend   <= 1'b0;
      end else begin
         restart_o <= 1'b0;
         if (stall && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
         if (running_o && cog_stop_in)
            stop_pend <= 1'b1;

         case (st)
            S_HALT: begin
               // Stop wins over a simultaneous start.
               if (cog_start_in && !cog_stop_in) begin
                  st          <= S_FETCH;
                  state_o     <= ST_FETCH;
                  running_o   <= 1'b1;
                  restart_o   <= 1'b1;
                  stall_cnt_o <= '0;
               end
            end
            S_FETCH: begin
               st      <= S_DECODE;
               state_o <= ST_DECODE;
            end
            S_DECODE: begin
               st      <= S_EXEC;
               state_o <= ST_EXECUTE;
            end
            S_EXEC: begin
               if (!stall) begin
                  st      <= S_WBACK;
                  state_o <= ST_WBACK;
               end
            end
            S_WBACK: begin
               // Stops only take effect on an instruction boundary.
               if (stop_pend || cog_stop_in) begin
                  st        <= S_HALT;
                  state_o   <= ST_FETCH;
                  running_o <= 1'b0;
                  stop_pend <= 1'b0;
               end else begin
                  st      <= S_FETCH;
                  state_o <= ST_FETCH;
               end
            end
            default: begin
               st        <= S_HALT;
               state_o   <= ST_FETCH;
               running_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acog_seq.sv
// Directed bench for acog_seq: pipeline stepping, hub/wait stalls, stop/start,
// stall counter saturation and asynchronous reset.
module tb_acog_seq;

   logic        clk_in = 1'b0;
   logic        resetn_in = 1'b1;
   logic        cog_start_in = 0, cog_stop_in = 0, execute_in = 0, is_hub_op_in = 0;
   logic        is_wait_in = 0, hub_ack_in = 0, wait_done_in = 0;
   logic [1:0]  state_o;
   logic        running_o, hub_req_o, stall_o, restart_o;
   logic [15:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;
   int nreq, nstall;

   acog_seq #(.BOOT_RUN(1'b1), .STALL_W(16)) dut (
      .clk_in(clk_in), .resetn_in(resetn_in),
      .cog_start_in(cog_start_in), .cog_stop_in(cog_stop_in),
      .execute_in(execute_in), .is_hub_op_in(is_hub_op_in), .is_wait_in(is_wait_in),
      .hub_ack_in(hub_ack_in), .wait_done_in(wait_done_in),
      .state_o(state_o), .running_o(running_o), .hub_req_o(hub_req_o),
      .stall_o(stall_o), .restart_o(restart_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      // Reset state
      #1 resetn_in = 1'b0;
      #2;
      chk("rst_state", state_o, 0);
      chk("rst_running", running_o, 1);
      chk("rst_hub_req", hub_req_o, 0);
      chk("rst_stall", stall_o, 0);
      chk("rst_restart", restart_o, 0);
      chk("rst_cnt", stall_cnt_o, 0);
      #9 resetn_in = 1'b1;

      // Free-running sequence 1,2,3,0,...
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("seq_state", state_o, (i + 1) % 4);
         chk("seq_running", running_o, 1);
         chk("seq_restart", restart_o, 0);
      end
      chk("seq_cnt", stall_cnt_o, 0);

      // Hub op acked on the 4th EXEC cycle
      execute_in = 1; is_hub_op_in = 1;
      tick(); chk("hub_dec_req", hub_req_o, 0);
      tick(); chk("hub_exec_state", state_o, 2);
      nreq = 0; nstall = 0;
      for (int k = 1; k <= 4; k++) begin
         hub_ack_in = (k == 4);
         #1;
         nreq += int'(hub_req_o);
         nstall += int'(stall_o);
         tick();
         hub_ack_in = 0;
      end
      chk("hub_req_cycles", nreq, 4);
      chk("hub_stall_cycles", nstall, 3);
      chk("hub_wb_state", state_o, 3);
      chk("hub_wb_req", hub_req_o, 0);
      chk("hub_cnt", stall_cnt_o, 3);
      hub_ack_in = 1; #1;
      chk("hub_stray_ack_stall", stall_o, 0);
      hub_ack_in = 0;
      tick(); chk("hub_back_fetch", state_o, 0);

      // Cancelled hub op
      execute_in = 0;
      tick(); tick();
      chk("cancel_state", state_o, 2);
      chk("cancel_req", hub_req_o, 0);
      chk("cancel_stall", stall_o, 0);
      tick();
      chk("cancel_wb", state_o, 3);
      chk("cancel_cnt", stall_cnt_o, 3);
      tick();

      // Stop during DECODE of a hub op acked after 2 stalls
      execute_in = 1;
      tick(); cog_stop_in = 1;
      tick(); cog_stop_in = 0;
      chk("stop_exec_req", hub_req_o, 1);
      tick(); chk("stop_exec2_stall", stall_o, 1);
      tick(); hub_ack_in = 1; #1;
      chk("stop_ack_stall", stall_o, 0);
      chk("stop_ack_req", hub_req_o, 1);
      tick(); hub_ack_in = 0;
      chk("stop_wb_state", state_o, 3);
      chk("stop_wb_running", running_o, 1);
      chk("stop_cnt", stall_cnt_o, 5);
      tick();
      chk("halt_running", running_o, 0);
      chk("halt_state", state_o, 0);
      for (int i = 0; i < 6; i++) begin
         execute_in = i[0]; is_hub_op_in = i[1]; is_wait_in = ~i[0];
         hub_ack_in = i[2]; wait_done_in = i[1];
         tick();
         chk("halt_hold_state", state_o, 0);
         chk("halt_hold_running", running_o, 0);
         chk("halt_hold_req", hub_req_o, 0);
         chk("halt_hold_stall", stall_o, 0);
      end
      execute_in = 0; is_hub_op_in = 0; is_wait_in = 0; hub_ack_in = 0; wait_done_in = 0;

      // Start and stop together: stay halted
      cog_start_in = 1; cog_stop_in = 1;
      tick();
      chk("both_running", running_o, 0);
      chk("both_restart", restart_o, 0);
      cog_stop_in = 0;
      tick(); cog_start_in = 0;
      chk("start_running", running_o, 1);
      chk("start_state", state_o, 0);
      chk("start_restart", restart_o, 1);
      chk("start_cnt", stall_cnt_o, 0);
      tick();
      chk("start_pulse_end", restart_o, 0);
      chk("start_decode", state_o, 1);
      cog_start_in = 1;
      tick(); cog_start_in = 0;
      chk("start_ignored", restart_o, 0);
      chk("start_ignored_state", state_o, 2);
      tick(); tick();

      // WAIT stall long enough to saturate the counter
      execute_in = 1; is_wait_in = 1;
      tick(); tick();
      chk("wait_exec_state", state_o, 2);
      repeat (65541) tick();
      chk("sat_cnt", stall_cnt_o, 16'hFFFF);
      chk("sat_stall", stall_o, 1);
      chk("sat_state", state_o, 2);
      is_hub_op_in = 1; wait_done_in = 1; #1;
      chk("prio_hub_req", hub_req_o, 1);
      chk("prio_hub_stall", stall_o, 1);
      is_hub_op_in = 0; #1;
      chk("wait_done_stall", stall_o, 0);
      is_hub_op_in = 1; #0;

      // Async reset mid-stall, no clock edge in between
      resetn_in = 0; #1;
      chk("arst_req", hub_req_o, 0);
      chk("arst_stall", stall_o, 0);
      chk("arst_cnt", stall_cnt_o, 0);
      chk("arst_state", state_o, 0);
      resetn_in = 1;
      tick();
      chk("arst_no_restart", restart_o, 0);
      chk("arst_decode", state_o, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
